clock_display_mux: RTL and testbench
====================================

Name: clock_display_mux

Overview:
- Sits directly downstream of the digital clock counter.
- Consumes its binary hours/minutes/seconds (6-bit each) and drives a 6-digit, time-multiplexed, common-cathode 7-segment display through user GPIO.
- Per frame: snapshots the time, converts each field to two BCD digits, and scans one digit at a time with an anti-ghosting blank gap.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot, including the gap. Legal range >= 2.
- BLANK_CYC, 500: all-off cycles at the end of each slot. Legal range 1 <= BLANK_CYC < SCAN_DIV.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- hours  input  6  binary hours; valid range 0-23.
- minutes  input  6  binary minutes; valid range 0-59.
- seconds  input  6  binary seconds; valid range 0-59.
- blank_lead  input  1  1 = blank hours-tens digit when hours < 10.
- colon_blink  input  1  1 = colon follows seconds parity; 0 = colon steady on.
- seg  output  7  segment drive, active high; seg[0]=a ... seg[6]=g.
- dp  output  1  decimal point / colon, active high.
- digit_en  output  6  one-hot digit select, active high; bit 0 = leftmost digit.
- seg_oeb  output  8  pad output enables for {dp,seg}; constant 0.
- digit_oeb  output  6  pad output enables for digit_en; constant 0.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high. All state changes only on posedge clk.
- Reset: seg=0, dp=0, digit_en=0, slot counter cnt=0, digit index idx=0, snapshot (h,m,s,blank_lead,colon_blink)=0. Reset asserted mid-frame aborts the scan at the next edge.
- cnt counts 0..SCAN_DIV-1, then wraps to 0. At the wrap, idx increments 0..5, then wraps to 0.
- Let A = SCAN_DIV-BLANK_CYC. Outputs are registered from (cnt, idx, snapshot), so they lag the counter by one cycle.
- When cnt < A: digit_en = 1<<idx.
- Otherwise (gap): digit_en=0, seg=0, dp=0.
- Timing from reset release (cycle 0 = first cycle with reset low):
  - Cycle 0: outputs still at reset values.
  - Digit i is active in cycles i*SCAN_DIV+1 .. i*SCAN_DIV+A.
  - Digit i is blank in cycles i*SCAN_DIV+A+1 .. (i+1)*SCAN_DIV.
- Snapshot: loaded from inputs on the edge where idx==5 and cnt==SCAN_DIV-1. The first frame after reset therefore shows 00:00:00 with the colon steady on. Input changes mid-frame never affect the current frame (no tearing).
- Digit map:
  - idx0 = hours tens, idx1 = hours ones.
  - idx2 = minutes tens, idx3 = minutes ones.
  - idx4 = seconds tens, idx5 = seconds ones.
- BCD conversion: tens = value/10, ones = value%10, for value 0-63. Purely combinational from the snapshot.
- Out-of-range field (hours > 23, minutes > 59 or seconds > 59): both digits of that field show dash (seg=7'h40). Other fields are unaffected.
- Segment codes (g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66.
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Leading-zero blank: if snapshot blank_lead=1 and hours < 10, idx0 gives seg=0. digit_en still asserts for that slot.
- Colon:
  - dp=1 only during active slots of idx1 and idx3, and only when colon_on.
  - colon_on = !colon_blink_snap | !seconds_snap[0].
  - dp is 0 on all other digits.
- Out-of-range has priority over leading-zero blank (dash shown).
- seg_oeb and digit_oeb are tied to 0 at all times, including reset.

Test Plan:
1. SCAN_DIV=8, BLANK_CYC=2; release reset -> cycle 0: all outputs 0. Cycles 1-6: digit_en=000001, seg=3F. Cycles 7-8: all 0. Cycle 9: digit_en=000010. First frame shows 00:00:00, dp=1 on idx1 and idx3.
2. Inputs 13:45:07, colon_blink=0, held through frame 0 -> frame 1 segs: 06,4F,66,6D,3F,07. dp=1 on idx1 and idx3.
3. hours=5, blank_lead=1, colon_blink=1, seconds=7 -> next frame: idx0 seg=00 with digit_en=000001, idx1 seg=6D, dp=0. With seconds=8 instead -> dp=1 on idx1 and idx3.
4. hours=24, minutes=60, seconds=59 -> idx0-3 seg=40, idx4 seg=6D, idx5 seg=6F.
5. Change inputs from 12:00:00 to 23:59:59 mid-frame (during idx2) -> remainder of that frame shows 12:00:00. The following frame shows 23:59:59.
6. Assert reset for 1 cycle during idx3 active -> next cycle all outputs 0, scan restarts at idx0 per scenario 1, and the frame shows 00:00:00. seg_oeb and digit_oeb read 0 throughout.

Source files
------------

// File: rtl/clock_display_mux_if.sv
// Time-field inputs and 7-segment pad outputs of the display multiplexer.
// The slave modport is the multiplexer; the master side supplies time and observes pads.
interface clock_display_mux_if;
    logic [5:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       blank_lead;
    logic       colon_blink;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] digit_en;
    logic [7:0] seg_oeb;
    logic [5:0] digit_oeb;

    modport slave (
        input  hours, minutes, seconds, blank_lead, colon_blink,
        output seg, dp, digit_en, seg_oeb, digit_oeb
    );

    modport master (
        output hours, minutes, seconds, blank_lead, colon_blink,
        input  seg, dp, digit_en, seg_oeb, digit_oeb
    );
endinterface

// File: rtl/clock_display_mux.sv
// Six-digit multiplexed 7-segment driver for HH:MM:SS, with a per-frame time snapshot,
// BCD split, dash on out-of-range fields, leading-zero blanking and a blank gap per slot.
module clock_display_mux #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    clock_display_mux_if.slave   bus
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ACT  = CW'(SCAN_DIV - BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [5:0]    h_snap_q, h_snap_d;
    logic [5:0]    m_snap_q, m_snap_d;
    logic [5:0]    s_snap_q, s_snap_d;
    logic          bl_snap_q, bl_snap_d;
    logic          cb_snap_q, cb_snap_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    digit_en_q, digit_en_d;

    logic          active;
    logic [5:0]    field;
    logic [5:0]    field_max;
    logic          out_of_range;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [3:0]    digit;
    logic          colon_on;

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [3:0] t;
        if (v >= 6'd60)      t = 4'd6;
        else if (v >= 6'd50) t = 4'd5;
        else if (v >= 6'd40) t = 4'd4;
        else if (v >= 6'd30) t = 4'd3;
        else if (v >= 6'd20) t = 4'd2;
        else if (v >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        return t;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Counter, digit index and frame snapshot
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        h_snap_d  = h_snap_q;
        m_snap_d  = m_snap_q;
        s_snap_d  = s_snap_q;
        bl_snap_d = bl_snap_q;
        cb_snap_d = cb_snap_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == 3'd5) begin
                idx_d     = 3'd0;
                h_snap_d  = bus.hours;
                m_snap_d  = bus.minutes;
                s_snap_d  = bus.seconds;
                bl_snap_d = bus.blank_lead;
                cb_snap_d = bus.colon_blink;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Digit content for the current slot, registered into the pad outputs
    always_comb begin
        active    = (cnt_q < CNT_ACT);
        colon_on  = !cb_snap_q || !s_snap_q[0];
        field     = s_snap_q;
        field_max = 6'd59;
        case (idx_q[2:1])
            2'd0: begin
                field     = h_snap_q;
                field_max = 6'd23;
            end
            2'd1:    field = m_snap_q;
            default: field = s_snap_q;
        endcase
        out_of_range = (field > field_max);
        tens  = tens_of(field);
        ones  = 4'(field - (6'(tens) * 6'd10));
        digit = idx_q[0] ? ones : tens;

        seg_d      = 7'h00;
        dp_d       = 1'b0;
        digit_en_d = 6'b0;
        if (active) begin
            digit_en_d = 6'b000001 << idx_q;
            if (out_of_range)
                seg_d = 7'h40;
            else if ((idx_q == 3'd0) && bl_snap_q && (h_snap_q < 6'd10))
                seg_d = 7'h00;
            else
                seg_d = seg_code(digit);
            dp_d = colon_on && ((idx_q == 3'd1) || (idx_q == 3'd3));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            h_snap_q   <= 6'd0;
            m_snap_q   <= 6'd0;
            s_snap_q   <= 6'd0;
            bl_snap_q  <= 1'b0;
            cb_snap_q  <= 1'b0;
            seg_q      <= 7'h00;
            dp_q       <= 1'b0;
            digit_en_q <= 6'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            h_snap_q   <= h_snap_d;
            m_snap_q   <= m_snap_d;
            s_snap_q   <= s_snap_d;
            bl_snap_q  <= bl_snap_d;
            cb_snap_q  <= cb_snap_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            digit_en_q <= digit_en_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.digit_en  = digit_en_q;
    assign bus.seg_oeb   = 8'h00;
    assign bus.digit_oeb = 6'h00;
endmodule

// File: tb/tb_clock_display_mux.sv
// Directed bench for clock_display_mux with an 8-cycle slot and 2-cycle blank gap.
module tb_clock_display_mux;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 6 * SD;

    logic clk;
    logic reset;
    int   cyc;
    int   passed;
    int   total;

    clock_display_mux_if bus ();

    clock_display_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic advance_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic set_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                            input logic bl, input logic cb);
        bus.hours       = h;
        bus.minutes     = m;
        bus.seconds     = s;
        bus.blank_lead  = bl;
        bus.colon_blink = cb;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_time(6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        total++;
        if ({bus.digit_en, bus.seg, bus.dp, bus.seg_oeb, bus.digit_oeb} !== 28'd0)
            $display("FAIL reset_cycle0: en=%b seg=%h dp=%b oeb=%h/%h, want all 0",
                     bus.digit_en, bus.seg, bus.dp, bus.seg_oeb, bus.digit_oeb);
        else passed++;
    endtask

    task automatic test_first_frame();
        logic [6:0] es [6];
        logic [5:0] ed;
        es = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        ed = 6'b001010;
        // inputs changed now must not reach frame 0
        set_time(6'd13, 6'd45, 6'd7, 1'b0, 1'b0);
        for (int c = 1; c <= SD; c++) begin
            advance_to(c);
            total++;
            if (c <= SD - BC) begin
                if (bus.digit_en !== 6'b000001 || bus.seg !== 7'h3F || bus.dp !== 1'b0)
                    $display("FAIL first_slot0 cyc%0d: en=%b seg=%h dp=%b, want en=000001 seg=3f dp=0",
                             c, bus.digit_en, bus.seg, bus.dp);
                else passed++;
            end else begin
                if ({bus.digit_en, bus.seg, bus.dp} !== 14'd0)
                    $display("FAIL first_gap0 cyc%0d: en=%b seg=%h dp=%b, want all 0",
                             c, bus.digit_en, bus.seg, bus.dp);
                else passed++;
            end
        end
        for (int i = 1; i < 6; i++) begin
            advance_to(i * SD + 1);
            total++;
            if (bus.digit_en !== (6'b1 << i) || bus.seg !== es[i] || bus.dp !== ed[i])
                $display("FAIL first_frame slot%0d: en=%b seg=%h dp=%b, want en=%b seg=%h dp=%b",
                         i, bus.digit_en, bus.seg, bus.dp, 6'b1 << i, es[i], ed[i]);
            else passed++;
            advance_to(i * SD + SD - BC);
            total++;
            if (bus.digit_en !== (6'b1 << i) || bus.seg !== es[i])
                $display("FAIL first_frame_end slot%0d: en=%b seg=%h, want en=%b seg=%h",
                         i, bus.digit_en, bus.seg, 6'b1 << i, es[i]);
            else passed++;
            advance_to(i * SD + SD - BC + 1);
            total++;
            if ({bus.digit_en, bus.seg, bus.dp} !== 14'd0)
                $display("FAIL first_frame_gap slot%0d: en=%b seg=%h dp=%b, want all 0",
                         i, bus.digit_en, bus.seg, bus.dp);
            else passed++;
        end
        advance_to(FRAME - 1);
    endtask

    task automatic test_decode();
        logic [6:0] es [6];
        logic [5:0] ed;
        int base;
        es = '{7'h06, 7'h4F, 7'h66, 7'h6D, 7'h3F, 7'h07};
        ed = 6'b001010;
        set_time(6'd13, 6'd45, 6'd7, 1'b0, 1'b0);
        base = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            advance_to(base + i * SD + 1);
            total++;
            if (bus.digit_en !== (6'b1 << i) || bus.seg !== es[i] || bus.dp !== ed[i])
                $display("FAIL decode slot%0d: en=%b seg=%h dp=%b, want en=%b seg=%h dp=%b",
                         i, bus.digit_en, bus.seg, bus.dp, 6'b1 << i, es[i], ed[i]);
            else passed++;
        end
        advance_to(base + FRAME - 1);
    endtask

    task automatic test_blank_lead();
        logic [6:0] es [6];
        logic [5:0] ed;
        int base;
        es = '{7'h00, 7'h6D, 7'h66, 7'h6D, 7'h3F, 7'h07};
        ed = 6'b000000;
        set_time(6'd5, 6'd45, 6'd7, 1'b1, 1'b1);
        base = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            advance_to(base + i * SD + 1);
            total++;
            if (bus.digit_en !== (6'b1 << i) || bus.seg !== es[i] || bus.dp !== ed[i])
                $display("FAIL blank_lead slot%0d: en=%b seg=%h dp=%b, want en=%b seg=%h dp=%b",
                         i, bus.digit_en, bus.seg, bus.dp, 6'b1 << i, es[i], ed[i]);
            else passed++;
        end
        advance_to(base + FRAME - 1);
    endtask

    task automatic test_colon_parity();
        logic [6:0] es [6];
        logic [5:0] ed;
        int base;
        es = '{7'h00, 7'h6D, 7'h66, 7'h6D, 7'h3F, 7'h7F};
        ed = 6'b001010;
        set_time(6'd5, 6'd45, 6'd8, 1'b1, 1'b1);
        base = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            advance_to(base + i * SD + 1);
            total++;
            if (bus.digit_en !== (6'b1 << i) || bus.seg !== es[i] || bus.dp !== ed[i])
                $display("FAIL colon_even slot%0d: en=%b seg=%h dp=%b, want en=%b seg=%h dp=%b",
                         i, bus.digit_en, bus.seg, bus.dp, 6'b1 << i, es[i], ed[i]);
            else passed++;
        end
        advance_to(base + FRAME - 1);
    endtask

    task automatic test_out_of_range();
        logic [6:0] es [6];
        logic [5:0] ed;
        int base;
        es = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h6D, 7'h6F};
        ed = 6'b001010;
        set_time(6'd24, 6'd60, 6'd59, 1'b1, 1'b0);
        base = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            advance_to(base + i * SD + 1);
            total++;
            if (bus.digit_en !== (6'b1 << i) || bus.seg !== es[i] || bus.dp !== ed[i])
                $display("FAIL out_of_range slot%0d: en=%b seg=%h dp=%b, want en=%b seg=%h dp=%b",
                         i, bus.digit_en, bus.seg, bus.dp, 6'b1 << i, es[i], ed[i]);
            else passed++;
        end
        advance_to(base + FRAME - 1);
    endtask

    task automatic test_no_tearing();
        logic [6:0] es [6];
        logic [6:0] en [6];
        logic [5:0] ed;
        int base;
        es = '{7'h06, 7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        en = '{7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F};
        ed = 6'b001010;
        set_time(6'd12, 6'd0, 6'd0, 1'b0, 1'b0);
        base = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            advance_to(base + i * SD + 1);
            total++;
            if (bus.digit_en !== (6'b1 << i) || bus.seg !== es[i] || bus.dp !== ed[i])
                $display("FAIL no_tear_old slot%0d: en=%b seg=%h dp=%b, want en=%b seg=%h dp=%b",
                         i, bus.digit_en, bus.seg, bus.dp, 6'b1 << i, es[i], ed[i]);
            else passed++;
            if (i == 2) set_time(6'd23, 6'd59, 6'd59, 1'b0, 1'b0);
        end
        advance_to(base + FRAME - 1);
        base = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            advance_to(base + i * SD + 1);
            total++;
            if (bus.digit_en !== (6'b1 << i) || bus.seg !== en[i] || bus.dp !== ed[i])
                $display("FAIL no_tear_new slot%0d: en=%b seg=%h dp=%b, want en=%b seg=%h dp=%b",
                         i, bus.digit_en, bus.seg, bus.dp, 6'b1 << i, en[i], ed[i]);
            else passed++;
        end
        advance_to(base + FRAME - 1);
    endtask

    task automatic test_reset_midframe();
        logic [6:0] es [6];
        logic [5:0] ed;
        int base;
        es = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        ed = 6'b001010;
        base = cyc + 1;
        advance_to(base + 3 * SD + 2);
        total++;
        if (bus.digit_en !== 6'b001000 || bus.seg !== 7'h6F)
            $display("FAIL pre_reset_idx3: en=%b seg=%h, want en=001000 seg=6f",
                     bus.digit_en, bus.seg);
        else passed++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        total++;
        if ({bus.digit_en, bus.seg, bus.dp, bus.seg_oeb, bus.digit_oeb} !== 28'd0)
            $display("FAIL midframe_reset: en=%b seg=%h dp=%b oeb=%h/%h, want all 0",
                     bus.digit_en, bus.seg, bus.dp, bus.seg_oeb, bus.digit_oeb);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            advance_to(i * SD + 1);
            total++;
            if (bus.digit_en !== (6'b1 << i) || bus.seg !== es[i] || bus.dp !== ed[i]
                || bus.seg_oeb !== 8'h00 || bus.digit_oeb !== 6'h00)
                $display("FAIL restart slot%0d: en=%b seg=%h dp=%b oeb=%h/%h, want en=%b seg=%h dp=%b oeb=0",
                         i, bus.digit_en, bus.seg, bus.dp, bus.seg_oeb, bus.digit_oeb,
                         6'b1 << i, es[i], ed[i]);
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        cyc    = 0;
        reset  = 1'b1;
        test_reset();
        test_first_frame();
        test_decode();
        test_blank_lead();
        test_colon_parity();
        test_out_of_range();
        test_no_tearing();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
